// File: rtl/mdu_seq_if.sv
// Request/response handshake bundle for the mdu_seq divide sequencer.
// master: the pipeline side that issues divides and consumes results.
// slave : the sequencer itself.
interface mdu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer.
// It borrows the EX-stage ALU for one restoring-division step at a time.
// The sequencer drives alu_ctr/alu_a/alu_b and consumes alu_result in the same cycle.
// Optional feature macro MDU_SEQ_SKIP_EN: a CMP step whose quotient bit is 0
// skips the SUB step, which makes latency data-dependent.
module mdu_seq (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  mdu_seq_if.slave          bus,
  output logic              busy,
  output logic [3:0]        alu_ctr,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;  // reserved, never issued
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS_A = 3'd1,
    S_ABS_B = 3'd2,
    S_CMP   = 3'd3,
    S_SUB   = 3'd4,
    S_FIX   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e      state_q, state_d, state_nxt_s;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ge_q, ge_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic [31:0] rsh_s;
  logic        ge_next_s;
  logic [31:0] rem_fin_s;
  logic [31:0] fix_sel_s;
  logic        fix_neg_s;

  // Next-state, datapath register updates and ALU drive for each state.
  always_comb begin
    state_nxt_s = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    ge_d        = ge_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    alu_ctr     = 4'b0000;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    rsh_s       = {rem_q[30:0], quo_q[31]};
    ge_next_s   = 1'b0;
    rem_fin_s   = rem_q;
    fix_sel_s   = quo_q;
    fix_neg_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Flush suppresses the accept so no register is disturbed.
        if (bus.req_valid && !flush) begin
          op_d    = bus.req_op;
          rem_d   = 32'd0;
          quo_d   = bus.req_a;
          dvs_d   = bus.req_b;
          cnt_d   = 6'd0;
          ge_d    = 1'b0;
          neg_q_d = 1'b0;
          neg_r_d = 1'b0;
          if (bus.req_b == 32'd0) begin
            state_nxt_s = S_DONE;
            resp_data_d = bus.req_op[1] ? bus.req_a : 32'hFFFF_FFFF;
          end else if (!bus.req_op[0] && (bus.req_a == 32'h8000_0000) &&
                       (bus.req_b == 32'hFFFF_FFFF)) begin
            state_nxt_s = S_DONE;
            resp_data_d = bus.req_op[1] ? 32'd0 : 32'h8000_0000;
          end else if (!bus.req_op[0]) begin
            neg_q_d     = bus.req_a[31] ^ bus.req_b[31];
            neg_r_d     = bus.req_a[31];
            state_nxt_s = S_ABS_A;
          end else begin
            state_nxt_s = S_CMP;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end

      S_ABS_A: begin
        alu_ctr = ALU_SUB;
        alu_a   = 32'd0;
        alu_b   = quo_q;
        if (neg_r_q) begin
          quo_d = alu_result;
        end else begin
          quo_d = quo_q;
        end
        state_nxt_s = S_ABS_B;
      end

      S_ABS_B: begin
        alu_ctr = ALU_SUB;
        alu_a   = 32'd0;
        alu_b   = dvs_q;
        // dvs still holds the original divisor here, so bit 31 is its sign.
        if (dvs_q[31]) begin
          dvs_d = alu_result;
        end else begin
          dvs_d = dvs_q;
        end
        state_nxt_s = S_CMP;
      end

      S_CMP: begin
        alu_ctr = ALU_SLTU;
        alu_a   = rsh_s;
        alu_b   = dvs_q;
        // A dropped MSB means the shifted remainder exceeds any 32-bit divisor.
        ge_next_s   = rem_q[31] | ~alu_result[0];
        ge_d        = ge_next_s;
        rem_d       = rsh_s;
        quo_d       = {quo_q[30:0], ge_next_s};
        state_nxt_s = S_SUB;
`ifdef MDU_SEQ_SKIP_EN
        if (!ge_next_s) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            if (!op_q[0]) begin
              state_nxt_s = S_FIX;
            end else begin
              state_nxt_s = S_DONE;
              resp_data_d = op_q[1] ? rsh_s : {quo_q[30:0], 1'b0};
            end
          end else begin
            state_nxt_s = S_CMP;
          end
        end else begin
          state_nxt_s = S_SUB;
        end
`endif
      end

      S_SUB: begin
        alu_ctr   = ALU_SUB;
        alu_a     = rem_q;
        alu_b     = dvs_q;
        rem_fin_s = ge_q ? alu_result : rem_q;
        rem_d     = rem_fin_s;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          if (!op_q[0]) begin
            state_nxt_s = S_FIX;
          end else begin
            state_nxt_s = S_DONE;
            resp_data_d = op_q[1] ? rem_fin_s : quo_q;
          end
        end else begin
          state_nxt_s = S_CMP;
        end
      end

      S_FIX: begin
        fix_sel_s   = op_q[1] ? rem_q : quo_q;
        fix_neg_s   = op_q[1] ? neg_r_q : neg_q_q;
        alu_ctr     = ALU_SUB;
        alu_a       = 32'd0;
        alu_b       = fix_sel_s;
        resp_data_d = fix_neg_s ? alu_result : fix_sel_s;
        state_nxt_s = S_DONE;
      end

      S_DONE: begin
        if (bus.resp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end

      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase

    // Flush beats both accept and response handshake.
    state_d = flush ? S_IDLE : state_nxt_s;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      cnt_q       <= 6'd0;
      ge_q        <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      op_q        <= 2'b00;
      resp_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      ge_q        <= ge_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: table-driven vectors, multi-cycle corner
// sequences (response hold, flush, asynchronous reset) and random ops against
// a behavioural RV32M reference. The bench provides the combinational ALU.
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        busy;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  int total;
  int bad;

  mdu_seq_if bus_if ();

  mdu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus_if.slave),
    .busy       (busy),
    .alu_ctr    (alu_ctr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational EX-stage ALU.
  always_comb begin
    case (alu_ctr)
      4'b0000: alu_result = alu_a + alu_b;
      4'b1000: alu_result = alu_a - alu_b;
      4'b0011: alu_result = {31'd0, (alu_a < alu_b)};
      default: alu_result = 32'd0;
    endcase
  end

  // busy and resp_valid must never be high together.
  always @(negedge clk) begin
    if (rst_n && busy && bus_if.resp_valid) begin
      bad++;
      $display("FAIL busy_overlap: busy=%0b resp_valid=%0b required not both 1", busy, bus_if.resp_valid);
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (ovf) return 32'h8000_0000;
        else return 32'($signed(a) / $signed(b));
      end
      2'b01: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      2'b10: begin
        if (b == 32'd0) return a;
        else if (ovf) return 32'd0;
        else return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return op[0] ? 65 : 68;
  endfunction

  // Issue one request, wait for the response, check value and latency, handshake.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int lat;
    @(negedge clk);
    check({name, " req_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    lat = 1;
    while (bus_if.resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " data"}, bus_if.resp_data, exp);
    check({name, " latency"}, 32'(lat), 32'(lat_exp));
    @(negedge clk);
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.resp_ready = 1'b0;
    check({name, " ready_after"}, {31'd0, bus_if.req_ready}, 32'd1);
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    rst_n             = 1'b0;
    flush             = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = 2'b00;
    bus_if.req_a      = 32'd0;
    bus_if.req_b      = 32'd0;
    bus_if.resp_ready = 1'b0;

    //           op     a              b              expected       latency
    vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        65};
    vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         65};
    vecs[2]  = '{2'b00, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 68};
    vecs[3]  = '{2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 68};
    vecs[4]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[7]  = '{2'b11, 32'd5,         32'd0,         32'd5,         1};
    vecs[8]  = '{2'b00, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 68};
    vecs[9]  = '{2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         68};
    vecs[10] = '{2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        68};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 65};
    vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         65};
    vecs[13] = '{2'b00, 32'h8000_0000, 32'd2,         32'hC000_0000, 68};
    vecs[14] = '{2'b00, 32'h8000_0000, 32'd1,         32'h8000_0000, 68};
    vecs[15] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         65};
    vecs[16] = '{2'b11, 32'd3,         32'd5,         32'd3,         65};
    vecs[17] = '{2'b10, 32'd7,         32'd0,         32'd7,         1};

    // Reset state.
    #12;
    check("rst req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst resp_data", bus_if.resp_data, 32'd0);
    check("rst alu_ctr", {28'd0, alu_ctr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // DIVU 0xFFFFFFFF/1 with the consumer stalling for 10 cycles.
    begin
      int lat;
      @(negedge clk);
      bus_if.req_valid = 1'b1;
      bus_if.req_op    = 2'b01;
      bus_if.req_a     = 32'hFFFF_FFFF;
      bus_if.req_b     = 32'd1;
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      lat = 1;
      while (bus_if.resp_valid !== 1'b1 && lat < 200) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("hold latency", 32'(lat), 32'd65);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check($sformatf("hold valid c%0d", k), {31'd0, bus_if.resp_valid}, 32'd1);
        check($sformatf("hold data c%0d", k), bus_if.resp_data, 32'hFFFF_FFFF);
        check($sformatf("hold req_ready c%0d", k), {31'd0, bus_if.req_ready}, 32'd0);
      end
      bus_if.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.resp_ready = 1'b0;
      check("hold ready_after", {31'd0, bus_if.req_ready}, 32'd1);
    end

    // Flush at cycle +20 of a DIVU.
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 2'b01;
    bus_if.req_a     = 32'd1000;
    bus_if.req_b     = 32'd3;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("flush alu_ctr", {28'd0, alu_ctr}, 32'd0);
    check("flush alu_a", alu_a, 32'd0);
    check("flush alu_b", alu_b, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("flush no_resp", {31'd0, bus_if.resp_valid}, 32'd0);
    run_op("after_flush", 2'b01, 32'd9, 32'd3, 32'd3, 65);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 2'b00;
    bus_if.req_a     = 32'hFFFF_FF9C;
    bus_if.req_b     = 32'd7;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("arst resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst resp_data", bus_if.resp_data, 32'd0);
    check("arst alu_ctr", {28'd0, alu_ctr}, 32'd0);
    check("arst alu_a", alu_a, 32'd0);
    check("arst alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random ops against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", n), op, a, b, ref_model(op, a, b), ref_lat(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
